// File: rtl/stack_calc_core.sv
// RAM-backed stack calculator (PUSH/POP/ADD/SUB/TOP/CLR/INC/DEC) driving the display path.
// Optional build macro STACK_CALC_SAT_EN: saturating ADD/SUB that pulses err when clipped.
module stack_calc_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] disp_val,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              empty,
  output logic              full,
  output logic              err,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TWO    = ADDR_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_A, ST_RD_B, ST_EXEC, ST_WR, ST_FETCH
  } state_e;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
    OP_TOP  = 3'd4, OP_CLR = 3'd5, OP_DEC = 3'd6, OP_INC = 3'd7
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] spr_q, spr_d;
  logic [ADDR_W-1:0] dar_q, dar_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] top, rd_addr, wr_addr;
  logic              rd_en, wr_en;
  logic [DATA_W-1:0] result;
  logic              clip;

  assign top       = spr_q + A_ONE;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_FULL);
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = !busy;
  assign err       = err_q;
  assign disp_addr = dar_q;
  // The read register doubles as the display latch; it is only refreshed in RD_A/RD_B/FETCH.
  assign disp_val  = empty ? '0 : rd_q;

  always_comb begin
    rd_en   = (state_q == ST_RD_A) || (state_q == ST_RD_B) || (state_q == ST_FETCH);
    rd_addr = dar_q;
    if (state_q == ST_RD_A) rd_addr = top;
    if (state_q == ST_RD_B) rd_addr = spr_q + A_TWO;
    // A write landing on the reset edge is dropped.
    wr_en   = (state_q == ST_WR) && !rst;
    wr_addr = (op_q == OP_PUSH) ? spr_q : spr_q + A_TWO;
  end

  // B is the second entry (just read into rd_q), A the top entry held in a_q.
`ifdef STACK_CALC_SAT_EN
  logic [DATA_W:0] sum_x, diff_x;
  always_comb begin
    sum_x  = {1'b0, rd_q} + {1'b0, a_q};
    diff_x = {1'b0, rd_q} - {1'b0, a_q};
    if (op_q == OP_ADD) begin
      clip   = sum_x[DATA_W];
      result = clip ? '1 : sum_x[DATA_W-1:0];
    end else begin
      clip   = diff_x[DATA_W];
      result = clip ? '0 : diff_x[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    clip   = 1'b0;
    result = (op_q == OP_ADD) ? rd_q + a_q : rd_q - a_q;
  end
`endif

  // NOTE: the RAM array and its read register are deliberately left out of reset; memories do not
  // get a reset port, and stale contents are unreachable because count gates every visible read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= opnd_q;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values;
  // combinational blocks use blocking (=) so later statements see earlier results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PUSH;
      spr_q   <= '1;
      cnt_q   <= '0;
      dar_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      spr_q   <= spr_d;
      cnt_q   <= cnt_d;
      dar_q   <= dar_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets its hold/default value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    spr_d   = spr_q;
    cnt_d   = cnt_q;
    dar_d   = dar_q;
    opnd_d  = opnd_q;
    a_d     = a_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = op_e'(cmd_op);
          case (op_e'(cmd_op))
            OP_PUSH: if (full) err_d = 1'b1;
                     else begin opnd_d = cmd_data; state_d = ST_WR; end
            OP_POP:  if (empty) err_d = 1'b1;
                     else begin
                       spr_d   = top;
                       cnt_d   = cnt_q - CNT_ONE;
                       dar_d   = (cnt_q == CNT_ONE) ? '0 : spr_q + A_TWO;
                       state_d = ST_FETCH;
                     end
            OP_ADD,
            OP_SUB:  if (empty || cnt_q == CNT_ONE) err_d = 1'b1;
                     else state_d = ST_RD_A;
            OP_TOP:  begin dar_d = top; state_d = ST_FETCH; end
            OP_CLR:  begin spr_d = '1; cnt_d = '0; dar_d = '0; state_d = ST_FETCH; end
            OP_DEC:  if (empty || dar_q == top) err_d = 1'b1;
                     else begin dar_d = dar_q - A_ONE; state_d = ST_FETCH; end
            OP_INC:  if (empty || dar_q == '1) err_d = 1'b1;
                     else begin dar_d = dar_q + A_ONE; state_d = ST_FETCH; end
          endcase
        end
      end
      ST_RD_A: state_d = ST_RD_B;
      ST_RD_B: begin a_d = rd_q; state_d = ST_EXEC; end
      ST_EXEC: begin opnd_d = result; err_d = clip; state_d = ST_WR; end
      ST_WR: begin
        if (op_q == OP_PUSH) begin
          spr_d = spr_q - A_ONE;
          cnt_d = cnt_q + CNT_ONE;
          dar_d = spr_q;
        end else begin
          spr_d = top;
          cnt_d = cnt_q - CNT_ONE;
          dar_d = spr_q + A_TWO;
        end
        state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_calc_core.sv
// Self-checking bench for stack_calc_core (DEPTH=4): directed table, reset-abort sequence,
// and randomized commands scored against a queue-based stack model.
module tb_stack_calc_core;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int PUSH = 0, POP = 1, ADD = 2, SUB = 3, TOP = 4, CLR = 5, DEC = 6, INC = 7;

`ifdef STACK_CALC_SAT_EN
  localparam int SAT_ERR = 1, SUB_RES = 8'h00, ADD_RES = 8'hFF;
`else
  localparam int SAT_ERR = 0, SUB_RES = 8'hFE, ADD_RES = 8'h10;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [DATA_W-1:0] disp_val;
  logic [ADDR_W-1:0] disp_addr;
  logic              empty, full, err, busy;

  always #5 clk = ~clk;

  stack_calc_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .disp_val(disp_val), .disp_addr(disp_addr),
    .empty(empty), .full(full), .err(err), .busy(busy)
  );

  typedef struct {
    int op; int data;
    int e_err; int e_lat; int e_disp; int e_addr; int e_empty; int e_full;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: stk[0] is the top entry; the top lives at address DEPTH-size (mod DEPTH).
  int stk[$];
  int dar_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int top_addr();
    return (DEPTH - stk.size()) % DEPTH;
  endfunction

  function automatic int model_disp();
    if (stk.size() == 0) return 0;
    return stk[dar_m - top_addr()];
  endfunction

  task automatic model_cmd(input int op, input int d, output int e_err, output int e_lat);
    int a, b, r;
    e_err = 0;
    e_lat = 0;
    case (op)
      PUSH: if (stk.size() == DEPTH) e_err = 1;
            else begin stk.push_front(d); dar_m = top_addr(); e_lat = 2; end
      POP:  if (stk.size() == 0) e_err = 1;
            else begin void'(stk.pop_front()); dar_m = top_addr(); e_lat = 1; end
      ADD, SUB: if (stk.size() < 2) e_err = 1;
            else begin
              a = stk.pop_front();
              b = stk.pop_front();
              r = (op == ADD) ? b + a : b - a;
`ifdef STACK_CALC_SAT_EN
              if (r > 255) begin r = 255; e_err = 1; end
              if (r < 0)   begin r = 0;   e_err = 1; end
`else
              r = (r + 256) % 256;
`endif
              stk.push_front(r);
              dar_m = top_addr();
              e_lat = 5;
            end
      TOP:  begin dar_m = top_addr(); e_lat = 1; end
      CLR:  begin stk.delete(); dar_m = 0; e_lat = 1; end
      DEC:  if (stk.size() == 0 || dar_m == top_addr()) e_err = 1;
            else begin dar_m--; e_lat = 1; end
      default: if (stk.size() == 0 || dar_m == DEPTH - 1) e_err = 1;
            else begin dar_m++; e_lat = 1; end
    endcase
  endtask

  // Issues one command from IDLE, then watches until IDLE again while throwing junk
  // commands at the DUT during the busy cycles (they must be ignored).
  task automatic issue(input int op, input int d,
                       output int err_seen, output int busy_seen, output int ready_bad);
    bit done = 1'b0;
    @(negedge clk);
    check("err_low_before_cmd", err, 0);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_op    = 3'(op);
    cmd_data  = 8'(d);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    err_seen  = 0;
    busy_seen = 0;
    ready_bad = 0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (err) err_seen++;
      if (cmd_ready == busy) ready_bad++;
      if (busy) begin
        busy_seen++;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom);
        cmd_data  = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
        done      = 1'b1;
      end
    end
    check("idle_reached", done, 1);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int me, ml, es, bs, rb;
    model_cmd(v.op, v.data, me, ml);
    issue(v.op, v.data, es, bs, rb);
    check($sformatf("vec%0d_err_pulses", idx), es, v.e_err);
    check($sformatf("vec%0d_busy_cycles", idx), bs, v.e_lat);
    check($sformatf("vec%0d_ready_vs_busy", idx), rb, 0);
    check($sformatf("vec%0d_disp_val", idx), disp_val, v.e_disp);
    check($sformatf("vec%0d_disp_addr", idx), disp_addr, v.e_addr);
    check($sformatf("vec%0d_empty", idx), empty, v.e_empty);
    check($sformatf("vec%0d_full", idx), full, v.e_full);
  endtask

  task automatic apply_model(input int op, input int d, input int idx);
    int me, ml, es, bs, rb;
    model_cmd(op, d, me, ml);
    issue(op, d, es, bs, rb);
    check($sformatf("rnd%0d_op%0d_err_pulses", idx, op), es, me);
    check($sformatf("rnd%0d_op%0d_busy_cycles", idx, op), bs, ml);
    check($sformatf("rnd%0d_ready_vs_busy", idx), rb, 0);
    check($sformatf("rnd%0d_disp_val", idx), disp_val, model_disp());
    check($sformatf("rnd%0d_disp_addr", idx), disp_addr, dar_m);
    check($sformatf("rnd%0d_empty", idx), empty, stk.size() == 0);
    check($sformatf("rnd%0d_full", idx), full, stk.size() == DEPTH);
  endtask

  function automatic vec_t mk(int op, int d, int e_err, int e_lat, int e_disp,
                              int e_addr, int e_empty, int e_full);
    vec_t v;
    v.op = op; v.data = d; v.e_err = e_err; v.e_lat = e_lat; v.e_disp = e_disp;
    v.e_addr = e_addr; v.e_empty = e_empty; v.e_full = e_full;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //             op    data   err      lat disp     addr emp full
    vecs.push_back(mk(PUSH, 8'h05, 0,       2, 8'h05,   3, 0, 0));
    vecs.push_back(mk(PUSH, 8'h03, 0,       2, 8'h03,   2, 0, 0));
    vecs.push_back(mk(ADD,  0,     0,       5, 8'h08,   3, 0, 0));
    vecs.push_back(mk(POP,  0,     0,       1, 8'h00,   0, 1, 0));
    vecs.push_back(mk(PUSH, 8'h03, 0,       2, 8'h03,   3, 0, 0));
    vecs.push_back(mk(PUSH, 8'h05, 0,       2, 8'h05,   2, 0, 0));
    vecs.push_back(mk(SUB,  0,     SAT_ERR, 5, SUB_RES, 3, 0, 0));
    vecs.push_back(mk(CLR,  0,     0,       1, 8'h00,   0, 1, 0));
    vecs.push_back(mk(POP,  0,     1,       0, 8'h00,   0, 1, 0));
    vecs.push_back(mk(ADD,  0,     1,       0, 8'h00,   0, 1, 0));
    vecs.push_back(mk(INC,  0,     1,       0, 8'h00,   0, 1, 0));
    vecs.push_back(mk(PUSH, 8'h11, 0,       2, 8'h11,   3, 0, 0));
    vecs.push_back(mk(PUSH, 8'h22, 0,       2, 8'h22,   2, 0, 0));
    vecs.push_back(mk(PUSH, 8'h33, 0,       2, 8'h33,   1, 0, 0));
    vecs.push_back(mk(DEC,  0,     1,       0, 8'h33,   1, 0, 0));
    vecs.push_back(mk(INC,  0,     0,       1, 8'h22,   2, 0, 0));
    vecs.push_back(mk(INC,  0,     0,       1, 8'h11,   3, 0, 0));
    vecs.push_back(mk(INC,  0,     1,       0, 8'h11,   3, 0, 0));
    vecs.push_back(mk(TOP,  0,     0,       1, 8'h33,   1, 0, 0));
    vecs.push_back(mk(PUSH, 8'h44, 0,       2, 8'h44,   0, 0, 1));
    vecs.push_back(mk(PUSH, 8'h55, 1,       0, 8'h44,   0, 0, 1));
    vecs.push_back(mk(INC,  0,     0,       1, 8'h33,   1, 0, 1));
    vecs.push_back(mk(INC,  0,     0,       1, 8'h22,   2, 0, 1));
    vecs.push_back(mk(INC,  0,     0,       1, 8'h11,   3, 0, 1));
    vecs.push_back(mk(DEC,  0,     0,       1, 8'h22,   2, 0, 1));
    vecs.push_back(mk(ADD,  0,     0,       5, 8'h77,   1, 0, 0));
    vecs.push_back(mk(CLR,  0,     0,       1, 8'h00,   0, 1, 0));
    vecs.push_back(mk(PUSH, 8'hF0, 0,       2, 8'hF0,   3, 0, 0));
    vecs.push_back(mk(PUSH, 8'h20, 0,       2, 8'h20,   2, 0, 0));
    vecs.push_back(mk(ADD,  0,     SAT_ERR, 5, ADD_RES, 3, 0, 0));
    vecs.push_back(mk(ADD,  0,     1,       0, ADD_RES, 3, 0, 0));
    vecs.push_back(mk(POP,  0,     0,       1, 8'h00,   0, 1, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", cmd_ready, 1);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_disp_val", disp_val, 0);
    check("reset_disp_addr", disp_addr, 0);

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Reset arriving while an ADD sits in RD_B aborts it cleanly.
    apply_model(PUSH, 8'h01, 1000);
    apply_model(PUSH, 8'h02, 1001);
    @(negedge clk);
    cmd_op    = 3'(ADD);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_busy_in_rd_a", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_seq_busy_in_rd_b", busy, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_seq_busy", busy, 0);
    check("rst_seq_ready", cmd_ready, 1);
    check("rst_seq_empty", empty, 1);
    check("rst_seq_full", full, 0);
    check("rst_seq_disp_addr", disp_addr, 0);
    check("rst_seq_disp_val", disp_val, 0);
    stk.delete();
    dar_m = 0;
    apply_model(PUSH, 8'h7A, 1002);
    check("rst_seq_push_disp", disp_val, 8'h7A);

    for (int i = 0; i < 400; i++) begin
      int r, op;
      r = $urandom_range(0, 99);
      if      (r < 25) op = PUSH;
      else if (r < 40) op = POP;
      else if (r < 52) op = ADD;
      else if (r < 64) op = SUB;
      else if (r < 72) op = TOP;
      else if (r < 75) op = CLR;
      else if (r < 87) op = DEC;
      else             op = INC;
      apply_model(op, $urandom_range(0, 255), i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
